// File: rtl/dma_pkg.sv
// Shared definitions for the in_dma / out_dma block pair: AXI encodings
// and the read-DMA state type.
package dma_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } in_dma_state_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length calculator: the largest burst that fits the remaining word
// count, the MAX_BURST limit and the space left in the current 4 KB page.
module dma_burst_calc #(
    parameter int REM_W     = 11,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0]      addr,
    input  logic [REM_W-1:0] remaining,
    output logic [8:0]       blen
);

    logic [12:0] room;
    logic [31:0] lim;

    // min(remaining, MAX_BURST, words left before the 4 KB boundary)
    always_comb begin
        room = (13'h1000 - {1'b0, addr}) >> 3;
        lim  = 32'(remaining);
        if (32'(MAX_BURST) < lim) lim = 32'(MAX_BURST);
        if (32'(room) < lim)      lim = 32'(room);
        blen = 9'(lim);
    end

endmodule

// File: rtl/in_dma.sv
// Input read DMA: AXI4 INCR read bursts from DDR into a sequential BRAM
// write port. One burst outstanding at a time.
module in_dma
    import dma_pkg::*;
#(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_W    = 4,
    parameter int BRAM_ADDR_W = 10,
    parameter int MAX_BURST   = 16,
    parameter int STREAM_ID   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AXI_ADDR_W-1:0]   src_addr,
    input  logic [BRAM_ADDR_W:0]    num_words,
    output logic                    done,
    output logic                    busy,
    output logic                    error,
    output logic                    bram_we,
    output logic [BRAM_ADDR_W-1:0]  bram_waddr,
    output logic [AXI_DATA_W-1:0]   bram_wdata,
    output logic [AXI_ID_W-1:0]     m_axi_arid,
    output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [AXI_ID_W-1:0]     m_axi_rid,
    input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    in_dma_state_t state, next_state;

    logic [AXI_ADDR_W-1:0]  cur_addr;
    logic [BRAM_ADDR_W:0]   remaining;
    logic [8:0]             beat_cnt;
    logic [8:0]             burst_len;
    logic [BRAM_ADDR_W-1:0] wptr;
    logic [8:0]             blen;
    logic                   accept;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   last_beat;

    // rid and the forced-zero low address bits carry no information here
    logic unused_bits;
    assign unused_bits = ^{m_axi_rid, src_addr[2:0]};

    assign m_axi_arid    = AXI_ID_W'(STREAM_ID);
    assign m_axi_arsize  = SIZE_8B;
    assign m_axi_arburst = BURST_INCR;

    assign accept    = (state == S_IDLE) && start;
    assign ar_hs     = m_axi_arvalid && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign last_beat = (beat_cnt == 9'd1);

    dma_burst_calc #(
        .REM_W     (BRAM_ADDR_W + 1),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr      (cur_addr[11:0]),
        .remaining (remaining),
        .blen      (blen)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; after the final beat S_R holds one drain cycle
    // (beat_cnt == 0) so done lands the cycle after the last BRAM write
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start) next_state = (num_words == '0) ? S_DONE : S_AR;
            end
            S_AR: begin
                if (m_axi_arready) next_state = S_R;
            end
            S_R: begin
                if (beat_cnt == '0)
                    next_state = S_DONE;
                else if (r_hs && last_beat && remaining > (BRAM_ADDR_W + 1)'(1))
                    next_state = S_AR;
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_rready  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            S_AR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = cur_addr;
                m_axi_arlen   = 8'(blen - 9'd1);
                busy          = 1'b1;
            end
            S_R: begin
                m_axi_rready = (beat_cnt != '0);
                busy         = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address, remaining count, beat counter and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
            wptr      <= '0;
        end else begin
            if (accept && num_words != '0) begin
                cur_addr  <= {src_addr[AXI_ADDR_W-1:3], 3'b000};
                remaining <= num_words;
                wptr      <= '0;
            end
            if (state == S_AR && ar_hs) begin
                beat_cnt  <= blen;
                burst_len <= blen;
            end
            if (r_hs) begin
                beat_cnt  <= beat_cnt - 9'd1;
                remaining <= remaining - (BRAM_ADDR_W + 1)'(1);
                wptr      <= wptr + BRAM_ADDR_W'(1);
                if (last_beat)
                    cur_addr <= cur_addr + AXI_ADDR_W'({burst_len, 3'b000});
            end
        end
    end

    // Registered BRAM write port, one cycle behind each R handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we    <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
        end else begin
            bram_we <= r_hs;
            if (r_hs) begin
                bram_waddr <= wptr;
                bram_wdata <= m_axi_rdata;
            end
        end
    end

    // Sticky error flag: bad response or misplaced rlast; cleared on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error <= 1'b0;
        else if (accept)
            error <= 1'b0;
        else if (r_hs && (m_axi_rresp != RESP_OKAY || m_axi_rlast != last_beat))
            error <= 1'b1;
    end

endmodule

// File: tb/tb_in_dma.sv
// Scoreboard bench for in_dma: an AXI read slave model, a monitor that
// checks AR, BRAM-write and done events against queued expectations, and
// directed transfers with hand-derived burst splits.
module tb_in_dma;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [9:0] a; logic [63:0] d; } wr_t;
    typedef struct { logic err; logic prev_we; } dn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [10:0] num_words;
    logic        done, busy, error;
    logic        bram_we;
    logic [9:0]  bram_waddr;
    logic [63:0] bram_wdata;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    in_dma #(
        .AXI_ADDR_W  (32),
        .AXI_DATA_W  (64),
        .AXI_ID_W    (4),
        .BRAM_ADDR_W (10),
        .MAX_BURST   (16),
        .STREAM_ID   (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .src_addr (src_addr),
        .num_words (num_words), .done (done), .busy (busy), .error (error),
        .bram_we (bram_we), .bram_waddr (bram_waddr), .bram_wdata (bram_wdata),
        .m_axi_arid (m_axi_arid), .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen (m_axi_arlen), .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst), .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready), .m_axi_rid (m_axi_rid),
        .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp),
        .m_axi_rlast (m_axi_rlast), .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    ar_t exp_ar[$];
    wr_t exp_wr[$];
    dn_t exp_dn[$];
    ar_t sl_ar[$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int g_beat = 0;
    int err_beat = -1;
    bit stall = 1'b0;

    function automatic logic [63:0] ddr(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic add_ar(input logic [31:0] a, input logic [7:0] l);
        exp_ar.push_back(ar_t'{a, l});
    endtask

    task automatic add_writes(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_wr.push_back(wr_t'{10'(i), ddr(base + 32'(8 * i))});
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [10:0] n);
        @(posedge clk); #1;
        start = 1'b1; src_addr = a; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 3000);
        if (!done) fail_evt(name, "got no done pulse, expected one within 3000 cycles");
    endtask

    // AXI read slave: sample handshakes mid-cycle, update drives after the edge
    initial begin : slave
        logic ar_hs, r_hs;
        logic [31:0] cap_addr, a;
        logic [7:0] cap_len;
        ar_t tmp;
        int sl_beat;
        sl_beat = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = 4'd1;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            cap_addr = m_axi_araddr;
            cap_len  = m_axi_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                sl_ar.delete();
                sl_beat = 0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                m_axi_rresp = 2'b00;
            end else begin
                if (r_hs && sl_ar.size() != 0) begin
                    g_beat++;
                    if (sl_beat == int'(sl_ar[0].len)) begin
                        tmp = sl_ar.pop_front();
                        sl_beat = 0;
                    end else begin
                        sl_beat++;
                    end
                    m_axi_rvalid = 1'b0;
                end
                if (ar_hs) sl_ar.push_back(ar_t'{cap_addr, cap_len});
                m_axi_arready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (sl_ar.size() == 0)
                    m_axi_rvalid = 1'b0;
                else if (!m_axi_rvalid)
                    m_axi_rvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (m_axi_rvalid) begin
                    a = sl_ar[0].addr + 32'(8 * sl_beat);
                    m_axi_rdata = ddr(a);
                    m_axi_rlast = (sl_beat == int'(sl_ar[0].len));
                    m_axi_rresp = (g_beat == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rlast = 1'b0;
                    m_axi_rresp = 2'b00;
                end
            end
        end
    end

    // Monitor: pop and compare on every DUT-presented event
    initial begin : monitor
        ar_t ea;
        wr_t ew;
        dn_t ed;
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_we = 1'b0;
            end else begin
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        fail_evt("ar_unexpected", "got an AR handshake, expected none");
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("araddr", m_axi_araddr, ea.addr);
                        chk("arlen", m_axi_arlen, ea.len);
                        chk("arsize", m_axi_arsize, 3'b011);
                        chk("arburst", m_axi_arburst, 2'b01);
                        chk("arid", m_axi_arid, 4'd1);
                    end
                end
                if (bram_we) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        fail_evt("wr_unexpected", "got a BRAM write, expected none");
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("bram_waddr", bram_waddr, ew.a);
                        chk("bram_wdata", bram_wdata, ew.d);
                    end
                end
                if (done) begin
                    if (exp_dn.size() == 0) begin
                        fail_evt("done_unexpected", "got a done pulse, expected none");
                    end else begin
                        ed = exp_dn.pop_front();
                        chk("done_error", error, ed.err);
                        chk("done_after_we", prev_we, ed.prev_we);
                        chk("done_busy", busy, 1'b0);
                    end
                end
                prev_we = bram_we;
            end
        end
    end

    initial begin : stimulus
        int k;
        rst_n = 1'b0; start = 1'b0; src_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_we", bram_we, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_arlen", m_axi_arlen, 8'd0);
        chk("rst_arsize", m_axi_arsize, 3'b011);
        #2 rst_n = 1'b1;

        // 25 words from 0x1000: bursts of 16 and 9 beats
        add_ar(32'h1000, 8'd15);
        add_ar(32'h1080, 8'd8);
        add_writes(32'h1000, 25);
        exp_dn.push_back(dn_t'{1'b0, 1'b1});
        pulse_start(32'h1000, 11'd25);
        @(negedge clk);
        chk("arvalid_after_start", m_axi_arvalid, 1'b1);
        chk("busy_after_start", busy, 1'b1);
        wait_done("t1_done");

        // 4 words from 0x1FF0: split at the 4 KB boundary
        add_ar(32'h1FF0, 8'd1);
        add_ar(32'h2000, 8'd1);
        add_writes(32'h1FF0, 4);
        exp_dn.push_back(dn_t'{1'b0, 1'b1});
        pulse_start(32'h1FF7, 11'd4);
        wait_done("t2_done");

        // zero-length transfer: done next cycle, never busy, no AR
        exp_dn.push_back(dn_t'{1'b0, 1'b0});
        pulse_start(32'h4000, 11'd0);
        @(negedge clk);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_busy_after", busy, 1'b0);
            chk("zero_arvalid", m_axi_arvalid, 1'b0);
        end

        // SLVERR on beat 3 of 8 with random stalls
        stall = 1'b1;
        err_beat = g_beat + 2;
        add_ar(32'h3000, 8'd7);
        add_writes(32'h3000, 8);
        exp_dn.push_back(dn_t'{1'b1, 1'b1});
        pulse_start(32'h3000, 11'd8);
        wait_done("t4_done");
        @(negedge clk);
        chk("error_sticky", error, 1'b1);
        stall = 1'b0;
        err_beat = -1;

        // next start clears the error
        add_ar(32'h0040, 8'd3);
        add_writes(32'h0040, 4);
        exp_dn.push_back(dn_t'{1'b0, 1'b1});
        pulse_start(32'h0040, 11'd4);
        @(negedge clk);
        chk("error_cleared", error, 1'b0);
        wait_done("t5_done");

        // reset during beat 5 of an 8-beat burst
        add_ar(32'h5000, 8'd7);
        add_writes(32'h5000, 4);
        k = wr_seen + 4;
        pulse_start(32'h5000, 11'd8);
        begin : wait_beats
            int c;
            c = 0;
            while (wr_seen < k && c < 500) begin
                @(negedge clk);
                c++;
            end
            if (wr_seen < k) fail_evt("reset_wait", "got too few BRAM writes before reset point");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_we", bram_we, 1'b0);
        chk("mid_rst_waddr", bram_waddr, 10'd0);
        chk("mid_rst_wdata", bram_wdata, 64'd0);
        chk("mid_rst_rready", m_axi_rready, 1'b0);
        chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        add_ar(32'h6000, 8'd3);
        add_writes(32'h6000, 4);
        exp_dn.push_back(dn_t'{1'b0, 1'b1});
        pulse_start(32'h6000, 11'd4);
        wait_done("t6_done");

        // start while busy and start coincident with done are both ignored
        add_ar(32'h8000, 8'd15);
        add_ar(32'h8080, 8'd3);
        add_writes(32'h8000, 20);
        exp_dn.push_back(dn_t'{1'b0, 1'b1});
        pulse_start(32'h8000, 11'd20);
        repeat (5) @(posedge clk);
        #1 start = 1'b1; src_addr = 32'hF000; num_words = 11'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t7_done");
        start = 1'b1; src_addr = 32'hA000; num_words = 11'd5;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ignored_start_busy", busy, 1'b0);
        end

        chk("exp_ar_left", 64'(exp_ar.size()), 64'd0);
        chk("exp_wr_left", 64'(exp_wr.size()), 64'd0);
        chk("exp_dn_left", 64'(exp_dn.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
